sargantana_icache_repl_ctrl: RTL and testbench
==============================================

SARGANTANA_ICACHE_REPL_CTRL -- requirements
Module: sargantana_icache_repl_ctrl

Interface
REQ-001 SHALL have parameter N_WAY, default 4, associativity; power of two, 2..16.
REQ-002 SHALL have parameter N_SET, default 64, number of sets; power of two, at least 2.
REQ-003 SHALL derive WAY_W = log2(N_WAY) and IDX_W = log2(N_SET).
REQ-004 SHALL have ports, as name direction width meaning:
- clk_i  in  1  clock.
- rstn_i  in  1  reset; one clock; reset is synchronous and active-low.
- flush_i  in  1  start full-cache flush (pulse).
- rd_ena_i  in  1  core lookup.
- rd_idx_i  in  IDX_W  lookup set.
- hit_i  in  1  lookup hit.
- hit_way_i  in  WAY_W  hit way.
- miss_alloc_i  in  1  capture victim for rd_idx_i.
- way_valid_bits_i  in  N_WAY  valid bits of rd_idx_i.
- wr_ena_i  in  1  refill write into captured way.
- inval_valid_i  in  1  invalidation request.
- inval_ready_o  out  1  invalidation accepted.
- inval_all_i  in  1  invalidate all ways of the set.
- inval_idx_i  in  IDX_W  set to invalidate.
- inval_way_i  in  WAY_W  way to invalidate.
- flush_busy_o  out  1  flush walk active.
- way_to_replace_o  out  WAY_W  combinational victim.
- way_to_replace_q_o  out  WAY_W  captured victim.
- we_valid_o  out  1  valid-bit RAM write enable.
- valid_wdata_o  out  1  value written to the valid bits.
- addr_valid_o  out  IDX_W  valid/tag RAM set address.
- tag_req_valid_o  out  N_WAY  tag RAM way enables.
- data_req_valid_o  out  N_WAY  data RAM way enables.

Function
REQ-005 SHALL run an FSM with states IDLE and FLUSH; flush_i in IDLE moves to FLUSH next cycle.
REQ-006 SHALL, in FLUSH, walk a set counter from 0 to N_SET-1, one set per cycle: addr_valid_o = counter, tag_req_valid_o all ones, we_valid_o=1, valid_wdata_o=0; the set's PLRU bits are cleared.
REQ-007 SHALL return to IDLE after the cycle with counter = N_SET-1; flush latency is exactly N_SET cycles; flush_i during FLUSH is ignored.
REQ-008 SHALL hold flush_busy_o=1 throughout FLUSH; inval_ready_o=0, and rd_ena_i, wr_ena_i and miss_alloc_i are ignored.
REQ-009 SHALL, in IDLE, apply priority invalidation > write > read for RAM outputs.
REQ-010 SHALL set inval_ready_o = IDLE and not wr_ena_i; a transfer occurs when valid and ready are both high, completes in that cycle, and drives addr_valid_o=inval_idx_i, we_valid_o=1, valid_wdata_o=0, tag_req_valid_o = all ones if inval_all_i else onehot(inval_way_i).
REQ-011 SHALL, on wr_ena_i, drive addr_valid_o=rd_idx_i, we_valid_o=1, valid_wdata_o=1, and tag_req_valid_o = data_req_valid_o = onehot(way_to_replace_q_o).
REQ-012 SHALL, on rd_ena_i alone, drive tag_req_valid_o and data_req_valid_o all ones and addr_valid_o=rd_idx_i; otherwise data_req_valid_o=0 and addr_valid_o=rd_idx_i.
REQ-013 SHALL drive way_to_replace_o as the lowest-index zero bit of way_valid_bits_i if any, else the tree-PLRU victim of rd_idx_i.
REQ-014 SHALL register way_to_replace_o into way_to_replace_q_o on miss_alloc_i in IDLE; it holds otherwise.
REQ-015 SHALL keep N_WAY-1 tree-PLRU bits per set: bit 0 selects the lower half, the victim follows the bits, and an access to way w sets every node on w's path to point away from w.
REQ-016 SHALL update PLRU the cycle after rd_ena_i&hit_i (way hit_way_i) or wr_ena_i (way way_to_replace_q_o); when both target the same set, the write update wins.
REQ-017 SHALL not alter PLRU state on invalidation.

Reset
REQ-018 SHALL on rstn_i=0 clear the PLRU bits, set counter and way_to_replace_q_o to 0, and enter FLUSH at the next edge after release; flush_busy_o=1 for N_SET cycles.
REQ-019 SHALL, when reset is asserted mid-flush, restart the walk from set 0.

Configuration
REQ-020 SHALL, with ICACHE_REPL_LFSR_EN defined, replace PLRU victim selection with an 8-bit LFSR (x^8+x^6+x^5+x^4+1, reset 8'h01, advances on each wr_ena_i) whose low WAY_W bits give the victim; PLRU storage is omitted. Without the macro, tree-PLRU is used.

Verification
REQ-021 Reset release, N_SET=64 -> flush_busy_o=1 for 64 cycles, addr_valid_o 0..63, we_valid_o=1, valid_wdata_o=0.
REQ-022 way_valid_bits_i=4'b1011, miss_alloc_i -> way_to_replace_q_o=2 next cycle.
REQ-023 All valid; hits on set 5, ways 0,1,2,3 -> victim for set 5 is way 0 (tree bits 3'b000).
REQ-024 Same-cycle inval_valid_i and wr_ena_i -> inval_ready_o=0, write proceeds; invalidation accepted next cycle.
REQ-025 inval_all_i=1, idx 9 -> tag_req_valid_o=4'b1111, we_valid_o=1, valid_wdata_o=0, addr_valid_o=9.
REQ-026 flush_i during FLUSH at counter 30 -> walk continues to 63, no restart.

Source files
------------

// File: rtl/sargantana_icache_repl_ctrl.sv
// I-cache replacement/valid-bit controller: flush walk, invalidation, refill and tree-PLRU victim choice.
// Define ICACHE_REPL_LFSR_EN to swap the PLRU victim for an 8-bit LFSR (PLRU storage is then dropped).
module sargantana_icache_repl_ctrl #(
  parameter  int N_WAY = 4,
  parameter  int N_SET = 64,
  localparam int WAY_W = $clog2(N_WAY),
  localparam int IDX_W = $clog2(N_SET)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             flush_i,
  input  logic             rd_ena_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic             hit_i,
  input  logic [WAY_W-1:0] hit_way_i,
  input  logic             miss_alloc_i,
  input  logic [N_WAY-1:0] way_valid_bits_i,
  input  logic             wr_ena_i,
  input  logic             inval_valid_i,
  output logic             inval_ready_o,
  input  logic             inval_all_i,
  input  logic [IDX_W-1:0] inval_idx_i,
  input  logic [WAY_W-1:0] inval_way_i,
  output logic             flush_busy_o,
  output logic [WAY_W-1:0] way_to_replace_o,
  output logic [WAY_W-1:0] way_to_replace_q_o,
  output logic             we_valid_o,
  output logic             valid_wdata_o,
  output logic [IDX_W-1:0] addr_valid_o,
  output logic [N_WAY-1:0] tag_req_valid_o,
  output logic [N_WAY-1:0] data_req_valid_o
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q;
  logic             rst_flush_q;
  logic [WAY_W-1:0] repl_q;
  logic [WAY_W-1:0] repl_way;
  logic             idle;
  logic             inval_fire;

  function automatic logic [N_WAY-1:0] onehot(input logic [WAY_W-1:0] w);
    return N_WAY'(1) << w;
  endfunction

  assign idle               = (state_q == IDLE);
  assign flush_busy_o       = (state_q == FLUSH);
  assign way_to_replace_q_o = repl_q;
  assign inval_ready_o      = idle && !wr_ena_i;
  assign inval_fire         = inval_valid_i && inval_ready_o;

  // rst_flush_q makes the first IDLE cycle after reset kick off the walk
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush_i || rst_flush_q) state_d = FLUSH;
      FLUSH:   if (cnt_q == IDX_W'(N_SET-1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we_valid_o       = 1'b0;
    valid_wdata_o    = 1'b0;
    addr_valid_o     = rd_idx_i;
    tag_req_valid_o  = '0;
    data_req_valid_o = '0;
    if (!idle) begin
      addr_valid_o    = cnt_q;
      tag_req_valid_o = '1;
      we_valid_o      = 1'b1;
    end else if (inval_fire) begin
      addr_valid_o    = inval_idx_i;
      we_valid_o      = 1'b1;
      tag_req_valid_o = inval_all_i ? '1 : onehot(inval_way_i);
    end else if (wr_ena_i) begin
      we_valid_o       = 1'b1;
      valid_wdata_o    = 1'b1;
      tag_req_valid_o  = onehot(repl_q);
      data_req_valid_o = onehot(repl_q);
    end else if (rd_ena_i) begin
      tag_req_valid_o  = '1;
      data_req_valid_o = '1;
    end
  end

  // An empty way always beats the replacement policy; lowest index first
  always_comb begin
    way_to_replace_o = repl_way;
    for (int i = N_WAY-1; i >= 0; i--)
      if (!way_valid_bits_i[i]) way_to_replace_o = WAY_W'(i);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      rst_flush_q <= 1'b1;
      cnt_q       <= '0;
      repl_q      <= '0;
    end else begin
      state_q <= state_d;
      if (idle) rst_flush_q <= 1'b0;
      if (!idle) cnt_q <= cnt_q + 1'b1;
      if (idle && miss_alloc_i) repl_q <= way_to_replace_o;
    end
  end

`ifdef ICACHE_REPL_LFSR_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) lfsr_q <= 8'h01;
    else if (idle && wr_ena_i)
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign repl_way = lfsr_q[WAY_W-1:0];
`else
  // Heap-ordered tree, node 1 is the root; a 0 bit points at the lower half
  typedef logic [N_WAY-1:1] tree_t;

  tree_t            plru_q [N_SET];
  logic             upd_vld_q;
  logic [IDX_W-1:0] upd_idx_q;
  logic [WAY_W-1:0] upd_way_q;

  function automatic logic [WAY_W-1:0] plru_victim(input tree_t t);
    logic [WAY_W:0] n;
    n = (WAY_W+1)'(1);
    for (int l = 0; l < WAY_W; l++) n = {n[WAY_W-1:0], t[n[WAY_W-1:0]]};
    return n[WAY_W-1:0];
  endfunction

  function automatic tree_t plru_touch(input tree_t t, input logic [WAY_W-1:0] w);
    tree_t            r;
    logic [WAY_W:0]   n;
    logic [WAY_W-1:0] ws;
    logic             d;
    r  = t;
    n  = (WAY_W+1)'(1);
    ws = w;
    for (int l = 0; l < WAY_W; l++) begin
      d  = ws[WAY_W-1];
      ws = ws << 1;
      r[n[WAY_W-1:0]] = ~d;
      n  = {n[WAY_W-1:0], d};
    end
    return r;
  endfunction

  assign repl_way = plru_victim(plru_q[rd_idx_i]);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      upd_vld_q <= 1'b0;
      upd_idx_q <= '0;
      upd_way_q <= '0;
      for (int s = 0; s < N_SET; s++) plru_q[s] <= '0;
    end else begin
      upd_vld_q <= idle && (wr_ena_i || (rd_ena_i && hit_i));
      upd_idx_q <= rd_idx_i;
      upd_way_q <= wr_ena_i ? repl_q : hit_way_i;
      if (upd_vld_q) plru_q[upd_idx_q] <= plru_touch(plru_q[upd_idx_q], upd_way_q);
      // flush clear is last so it wins over a same-set update
      if (!idle) plru_q[cnt_q] <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_sargantana_icache_repl_ctrl.sv
// Randomized bench for sargantana_icache_repl_ctrl against a range-splitting tree-PLRU reference model.
module tb_sargantana_icache_repl_ctrl;
  localparam int N_WAY = 4;
  localparam int N_SET = 64;
  localparam int WAY_W = 2;
  localparam int IDX_W = 6;

  logic             clk = 1'b0;
  logic             rstn;
  logic             flush, rd_ena, hit, miss_alloc, wr_ena, inval_valid, inval_all;
  logic [IDX_W-1:0] rd_idx, inval_idx;
  logic [WAY_W-1:0] hit_way, inval_way;
  logic [N_WAY-1:0] vbits;
  logic             inval_ready, flush_busy, we_valid, valid_wdata;
  logic [WAY_W-1:0] victim, victim_q;
  logic [IDX_W-1:0] addr_valid;
  logic [N_WAY-1:0] tag_req, data_req;

  int checks = 0;
  int errors = 0;
  int busy_cnt;

  // reference model state
  bit m_flush, m_pre, pv;
  int m_cnt, m_q, pidx, pway;
  bit m_plru [N_SET][2*N_WAY];

  sargantana_icache_repl_ctrl #(.N_WAY(N_WAY), .N_SET(N_SET)) dut (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .rd_ena_i(rd_ena), .rd_idx_i(rd_idx),
    .hit_i(hit), .hit_way_i(hit_way), .miss_alloc_i(miss_alloc), .way_valid_bits_i(vbits),
    .wr_ena_i(wr_ena), .inval_valid_i(inval_valid), .inval_ready_o(inval_ready),
    .inval_all_i(inval_all), .inval_idx_i(inval_idx), .inval_way_i(inval_way),
    .flush_busy_o(flush_busy), .way_to_replace_o(victim), .way_to_replace_q_o(victim_q),
    .we_valid_o(we_valid), .valid_wdata_o(valid_wdata), .addr_valid_o(addr_valid),
    .tag_req_valid_o(tag_req), .data_req_valid_o(data_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic int ref_victim(int s);
    int lo = 0, size = N_WAY, node = 1;
    while (size > 1) begin
      size = size / 2;
      if (m_plru[s][node]) begin lo += size; node = 2*node + 1; end
      else node = 2*node;
    end
    return lo;
  endfunction

  function automatic void ref_touch(int s, int w);
    int lo = 0, size = N_WAY, node = 1;
    bit upper;
    while (size > 1) begin
      size = size / 2;
      upper = (w >= lo + size);
      m_plru[s][node] = !upper;
      if (upper) begin lo += size; node = 2*node + 1; end
      else node = 2*node;
    end
  endfunction

  function automatic void ref_clear();
    foreach (m_plru[s, n]) m_plru[s][n] = 1'b0;
  endfunction

  function automatic int exp_victim();
    for (int i = 0; i < N_WAY; i++) if (!vbits[i]) return i;
    return ref_victim(int'(rd_idx));
  endfunction

  task automatic drive_idle();
    flush = 0; rd_ena = 0; hit = 0; miss_alloc = 0; wr_ena = 0; inval_valid = 0;
    inval_all = 0; rd_idx = '0; inval_idx = '0; hit_way = '0; inval_way = '0; vbits = '1;
  endtask

  // Called at posedge+1 with inputs applied: check outputs, advance model, move to next posedge+1
  task automatic step();
    int  ev;
    bit  e_rdy, e_we, e_wd;
    int  e_addr, e_tag, e_data;
    #3;
    ev = exp_victim();
    if (rstn) begin
      if (flush_busy) busy_cnt++;
      e_rdy = 0; e_we = 0; e_wd = 0; e_addr = int'(rd_idx); e_tag = 0; e_data = 0;
      if (m_flush) begin
        e_addr = m_cnt; e_we = 1; e_tag = 'hf;
      end else begin
        e_rdy = !wr_ena;
        if (inval_valid && !wr_ena) begin
          e_addr = int'(inval_idx); e_we = 1;
          e_tag = inval_all ? 'hf : (1 << inval_way);
        end else if (wr_ena) begin
          e_we = 1; e_wd = 1; e_tag = 1 << m_q; e_data = 1 << m_q;
        end else if (rd_ena) begin
          e_tag = 'hf; e_data = 'hf;
        end
        check("victim", victim, ev);
      end
      check("busy", flush_busy, m_flush);
      check("inval_ready", inval_ready, e_rdy);
      check("we_valid", we_valid, e_we);
      check("valid_wdata", valid_wdata, e_wd);
      check("addr_valid", addr_valid, e_addr);
      check("tag_req", tag_req, e_tag);
      check("data_req", data_req, e_data);
      check("victim_q", victim_q, m_q);
    end
    if (!rstn) begin
      m_flush = 0; m_pre = 1; m_cnt = 0; m_q = 0; pv = 0; ref_clear();
    end else if (m_flush) begin
      if (m_cnt == N_SET-1) m_flush = 0;
      m_cnt = (m_cnt + 1) % N_SET;
    end else begin
      if (pv) ref_touch(pidx, pway);
      pv   = wr_ena || (rd_ena && hit);
      pidx = int'(rd_idx);
      pway = wr_ena ? m_q : int'(hit_way);
      if (miss_alloc) m_q = ev;
      if (flush || m_pre) begin
        m_flush = 1; m_cnt = 0; m_pre = 0; pv = 0; ref_clear();
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Step through an active walk; flush_i is re-pulsed at set 30 and must be ignored
  task automatic run_flush(input string tag);
    busy_cnt = 0;
    for (int k = 0; k < 80; k++) begin
      if (!m_flush) break;
      flush = (m_cnt == 30);
      step();
    end
    flush = 0;
    check(tag, busy_cnt, N_SET);
  endtask

  initial begin
    rstn = 0;
    drive_idle();
    @(posedge clk); #1;
    step();
    check("rst_q", victim_q, 0);
    check("rst_busy", flush_busy, 0);
    rstn = 1;
    step();                                // first IDLE cycle launches the walk
    run_flush("flush_len");

    // lowest invalid way is captured
    drive_idle();
    rd_idx = 3; vbits = 4'b1011; miss_alloc = 1;
    #1 check("req022_comb", victim, 2);
    step();
    check("req022_q", victim_q, 2);

    // hits on all ways of set 5 leave the tree pointing at way 0
    drive_idle();
    rd_idx = 5; rd_ena = 1; hit = 1;
    for (int w = 0; w < N_WAY; w++) begin
      hit_way = WAY_W'(w);
      step();
    end
    drive_idle();
    rd_idx = 5;
    step();
    #1 check("req023_victim", victim, 0);
    step();

    // write blocks invalidation for one cycle
    drive_idle();
    rd_idx = 3; wr_ena = 1; inval_valid = 1; inval_idx = 7; inval_way = 1;
    #1 check("req024_rdy0", inval_ready, 0);
    check("req024_wd", valid_wdata, 1);
    step();
    wr_ena = 0;
    #1 check("req024_rdy1", inval_ready, 1);
    check("req024_addr", addr_valid, 7);
    check("req024_tag", tag_req, 4'b0010);
    step();

    drive_idle();
    inval_valid = 1; inval_all = 1; inval_idx = 9;
    #1 check("req025_tag", tag_req, 4'b1111);
    check("req025_addr", addr_valid, 9);
    check("req025_we", we_valid, 1);
    check("req025_wd", valid_wdata, 0);
    step();

    // software flush with a redundant flush_i mid-walk
    drive_idle();
    flush = 1;
    step();
    run_flush("req026_len");
    drive_idle();
    #1 check("req026_idle", flush_busy, 0);

    // reset mid-walk restarts from set 0
    flush = 1;
    step();
    flush = 0;
    repeat (10) step();
    rstn = 0;
    step();
    rstn = 1;
    step();
    run_flush("req019_len");

    // random traffic over a few sets so PLRU state gets reused
    for (int c = 0; c < 3000; c++) begin
      rd_idx      = IDX_W'($urandom_range(0, 7));
      vbits       = ($urandom_range(0, 3) == 0) ? N_WAY'($urandom) : '1;
      rd_ena      = 1'($urandom);
      hit         = 1'($urandom);
      hit_way     = WAY_W'($urandom);
      miss_alloc  = ($urandom_range(0, 4) == 0);
      wr_ena      = ($urandom_range(0, 4) == 0);
      inval_valid = ($urandom_range(0, 4) == 0);
      inval_all   = 1'($urandom);
      inval_idx   = IDX_W'($urandom);
      inval_way   = WAY_W'($urandom);
      flush       = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
